// File: rtl/id_issue_ctrl_pkg.sv
// Shared decode constants, FSM states and immediate helpers for the ID issue controller.
// Build option: BYPASS_EN (see id_hazard_chk) selects EX/MEM forwarding behaviour.
package id_issue_ctrl_pkg;

  localparam logic [6:0] Rtype   = 7'b0110011;
  localparam logic [6:0] Itype_J = 7'b1100111;
  localparam logic [6:0] Itype_L = 7'b0000011;
  localparam logic [6:0] Itype_A = 7'b0010011;
  localparam logic [6:0] Itype_C = 7'b1110011;
  localparam logic [6:0] Utype_L = 7'b0110111;
  localparam logic [6:0] Utype_A = 7'b0010111;
  localparam logic [6:0] Jtype_J = 7'b1101111;
  localparam logic [6:0] Btype   = 7'b1100011;
  localparam logic [6:0] Stype   = 7'b0100011;

  localparam logic [2:0] I_CSRRWI = 3'b101;
  localparam logic [2:0] I_CSRRSI = 3'b110;
  localparam logic [2:0] I_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      Rtype, Itype_J, Itype_L, Itype_A, Itype_C, Stype, Btype: uses_rs1 = 1'b1;
      default:                                                uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      Rtype, Stype, Btype: uses_rs2 = 1'b1;
      default:             uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    imm_gen = '0;
    case (i[6:0])
      Itype_J, Itype_L, Itype_A: imm_gen = {{20{i[31]}}, i[31:20]};
      Itype_C: begin
        if (i[14:12] == I_CSRRWI || i[14:12] == I_CSRRSI || i[14:12] == I_CSRRCI)
          imm_gen = {27'b0, i[19:15]};
      end
      Utype_L, Utype_A: imm_gen = {i[31:12], 12'b0};
      Jtype_J: imm_gen = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      Btype:   imm_gen = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      Stype:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      default: imm_gen = '0;
    endcase
  endfunction

endpackage

// File: rtl/id_hazard_chk.sv
// Combinational RAW hazard check of ID sources against EX/MEM destinations.
// BYPASS_EN defined: only EX load-use stalls; undefined: any EX/MEM producer stalls.
module id_hazard_chk (
  input  logic       rs1_use,
  input  logic       rs2_use,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  output logic       hazard
);

  logic rs1_live, rs2_live;
  logic ex_match, mem_match;

  // x0 never carries a dependence
  assign rs1_live  = rs1_use && (rs1 != '0);
  assign rs2_live  = rs2_use && (rs2 != '0);
  assign ex_match  = (rs1_live && rs1 == ex_rd)  || (rs2_live && rs2 == ex_rd);
  assign mem_match = (rs1_live && rs1 == mem_rd) || (rs2_live && rs2 == mem_rd);

`ifdef BYPASS_EN
  logic unused_mem;
  assign unused_mem = ^{mem_match, mem_wen};
  assign hazard     = ex_wen && ex_is_load && ex_match;
`else
  logic unused_load;
  assign unused_load = ex_is_load;
  assign hazard      = (ex_wen && ex_match) || (mem_wen && mem_match);
`endif

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: ID pipeline register, issue gating, stall FSM and stall counter.
// Build option: BYPASS_EN selects the forwarding-aware hazard check in id_hazard_chk.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_i,
  input  logic [31:0] if_inst_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_imm_o,
  output logic [4:0]  id_rs1_o,
  output logic [4:0]  id_rs2_o,
  input  logic        ex_ready_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_wen_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_wen_i,
  input  logic        ex_busy_i,
  input  logic        mem_busy_i,
  input  logic        flush_i,
  output logic [15:0] stall_cnt_o
);

  logic        full_q;
  logic [31:0] inst_q, pc_q;
  logic [15:0] cnt_q;
  state_t      state_q, state_d;

  logic [6:0]  opcode;
  logic        rs1_use, rs2_use;
  logic        hazard, csr_block, fire;

  assign opcode  = inst_q[6:0];
  assign rs1_use = uses_rs1(opcode);
  assign rs2_use = uses_rs2(opcode);

  assign id_inst_o = inst_q;
  assign id_pc_o   = pc_q;
  assign id_imm_o  = imm_gen(inst_q);
  assign id_rs1_o  = rs1_use ? inst_q[19:15] : '0;
  assign id_rs2_o  = rs2_use ? inst_q[24:20] : '0;

  id_hazard_chk u_hazard (
    .rs1_use    (rs1_use),
    .rs2_use    (rs2_use),
    .rs1        (id_rs1_o),
    .rs2        (id_rs2_o),
    .ex_rd      (ex_rd_i),
    .ex_wen     (ex_wen_i),
    .ex_is_load (ex_is_load_i),
    .mem_rd     (mem_rd_i),
    .mem_wen    (mem_wen_i),
    .hazard     (hazard)
  );

  // CSR accesses serialize: wait until no older instruction remains in EX/MEM
  assign csr_block  = full_q && (opcode == Itype_C) && (ex_busy_i || mem_busy_i);
  assign id_valid_o = full_q && !hazard && !csr_block && !flush_i;
  assign fire       = id_valid_o && ex_ready_i;
  assign if_ready_o = !full_q || fire || flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (if_valid_i && if_ready_o) begin
      full_q <= 1'b1;
      inst_q <= if_inst_i;
      pc_q   <= if_pc_i;
    end else if (fire) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (full_q && hazard)  state_d = ST_STALL;
          else if (csr_block)    state_d = ST_DRAIN;
        end
        ST_STALL: if (!(full_q && hazard))         state_d = ST_RUN;
        ST_DRAIN: if (!ex_busy_i && !mem_busy_i)   state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (full_q && !id_valid_o && !flush_i && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: issued instructions are checked against a queue of expectations.
module tb_id_issue_ctrl;
  import id_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i;
  logic [31:0] if_inst_i, if_pc_i;
  logic        if_ready_o, id_valid_o;
  logic [31:0] id_inst_o, id_pc_o, id_imm_o;
  logic [4:0]  id_rs1_o, id_rs2_o;
  logic        ex_ready_i;
  logic [4:0]  ex_rd_i, mem_rd_i;
  logic        ex_wen_i, ex_is_load_i, mem_wen_i, ex_busy_i, mem_busy_i, flush_i;
  logic [15:0] stall_cnt_o;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i), .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .id_imm_o(id_imm_o),
    .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o),
    .ex_ready_i(ex_ready_i), .ex_rd_i(ex_rd_i), .ex_wen_i(ex_wen_i), .ex_is_load_i(ex_is_load_i),
    .mem_rd_i(mem_rd_i), .mem_wen_i(mem_wen_i), .ex_busy_i(ex_busy_i), .mem_busy_i(mem_busy_i),
    .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;

  // Every issue (valid && ready, sampled mid-cycle) must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && id_valid_o && ex_ready_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got pc=%h inst=%h, expected no issue", id_pc_o, id_inst_o);
      end else begin
        mon_e = sb.pop_front();
        if ({id_pc_o, id_inst_o, id_imm_o, id_rs1_o, id_rs2_o} !==
            {mon_e.pc, mon_e.inst, mon_e.imm, mon_e.rs1, mon_e.rs2}) begin
          n_fail++;
          $display("FAIL issue_fields: got pc=%h inst=%h imm=%h rs1=%0d rs2=%0d, expected pc=%h inst=%h imm=%h rs1=%0d rs2=%0d",
                   id_pc_o, id_inst_o, id_imm_o, id_rs1_o, id_rs2_o,
                   mon_e.pc, mon_e.inst, mon_e.imm, mon_e.rs1, mon_e.rs2);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    ex_rd_i = '0; ex_wen_i = 1'b0; ex_is_load_i = 1'b0;
    mem_rd_i = '0; mem_wen_i = 1'b0; ex_busy_i = 1'b0; mem_busy_i = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit will_issue);
    exp_t e;
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
    if (will_issue) begin
      e.pc = pc; e.inst = inst; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; if_inst_i = '0; if_pc_i = '0;
    ex_ready_i = 1'b1; clear_pipe();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({if_ready_o, id_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_handshake: got ready=%b valid=%b, expected ready=1 valid=0", if_ready_o, id_valid_o);
    end
    n_checks++;
    if ({id_imm_o, id_rs1_o, id_rs2_o, stall_cnt_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got imm=%h rs1=%0d rs2=%0d cnt=%0d, expected all 0", id_imm_o, id_rs1_o, id_rs2_o, stall_cnt_o);
    end
    n_checks++;
    if (dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, ST_RUN);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    present(32'h100, 32'h00500093, 32'h5, 5'd0, 5'd0, 1'b1);
    step();
    if_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, id_imm_o, id_rs1_o, id_rs2_o} !== {1'b1, 32'h5, 5'd0, 5'd0}) begin
      n_fail++; $display("FAIL basic_addi: got valid=%b imm=%h rs1=%0d rs2=%0d, expected valid=1 imm=5 rs1=0 rs2=0",
                         id_valid_o, id_imm_o, id_rs1_o, id_rs2_o);
    end
    step();
  endtask

  task automatic test_no_false_hazard();
    logic [31:0] insts [2] = '{32'h00700093, 32'h000001B3};
    logic [31:0] imms  [2] = '{32'h7, 32'h0};
    logic [4:0]  rds   [2] = '{5'd7, 5'd0};
    for (int unsigned i = 0; i < 2; i++) begin
      ex_wen_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = rds[i];
      mem_wen_i = 1'b1; mem_rd_i = rds[i];
      present(32'h180 + 32'(i * 4), insts[i], imms[i], 5'd0, 5'd0, 1'b1);
      step();
      if_valid_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({id_valid_o, id_rs2_o} !== {1'b1, 5'd0}) begin
        n_fail++; $display("FAIL no_false_hazard[%0d]: got valid=%b rs2=%0d, expected valid=1 rs2=0", i, id_valid_o, id_rs2_o);
      end
      step();
    end
    clear_pipe();
  endtask

  task automatic test_load_use();
    present(32'h200, 32'h001101B3, 32'h0, 5'd2, 5'd1, 1'b1);
    step();
    if_valid_i = 1'b0;
    ex_wen_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
    @(negedge clk);
    n_checks++;
    if (id_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall: got valid=%b, expected 0", id_valid_o);
    end
    step();
    clear_pipe();
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL load_use_release: got valid=%b cnt=%0d, expected valid=1 cnt=%0d", id_valid_o, stall_cnt_o, exp_cnt);
    end
    n_checks++;
    if (dut.state_q !== ST_STALL) begin
      n_fail++; $display("FAIL load_use_fsm: got %0d, expected %0d", dut.state_q, ST_STALL);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL load_use_fsm_back: got %0d, expected %0d", dut.state_q, ST_RUN);
    end
    step();
  endtask

  task automatic test_raw_producers();
    // MEM producer on rs1
    present(32'h300, 32'h00108213, 32'h1, 5'd1, 5'd0, 1'b1);
    mem_rd_i = 5'd1; mem_wen_i = 1'b1;
    step();
    if_valid_i = 1'b0;
`ifdef BYPASS_EN
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL mem_raw_bypass: got valid=%b cnt=%0d, expected valid=1 cnt=%0d", id_valid_o, stall_cnt_o, exp_cnt);
    end
    step();
`else
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (id_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL mem_raw_stall[%0d]: got valid=%b, expected 0", k, id_valid_o);
      end
      step();
    end
    mem_wen_i = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL mem_raw_release: got valid=%b cnt=%0d, expected valid=1 cnt=%0d", id_valid_o, stall_cnt_o, exp_cnt);
    end
    step();
`endif
    clear_pipe();
    // EX non-load producer on rs2 of a store
    present(32'h340, 32'hFE532C23, 32'hFFFFFFF8, 5'd6, 5'd5, 1'b1);
    ex_rd_i = 5'd5; ex_wen_i = 1'b1;
    step();
    if_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
`ifdef BYPASS_EN
    if (id_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL ex_alu_raw_bypass: got valid=%b, expected 1", id_valid_o);
    end
    step();
`else
    if (id_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ex_alu_raw_stall: got valid=%b, expected 0", id_valid_o);
    end
    step();
    ex_wen_i = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL ex_alu_raw_release: got valid=%b cnt=%0d, expected valid=1 cnt=%0d", id_valid_o, stall_cnt_o, exp_cnt);
    end
    step();
`endif
    clear_pipe();
  endtask

  task automatic test_csr_drain();
    present(32'h400, 32'h300AD2F3, 32'h15, 5'd21, 5'd0, 1'b1);
    mem_busy_i = 1'b1;
    step();
    if_valid_i = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({id_valid_o, id_imm_o} !== {1'b0, 32'h15}) begin
        n_fail++; $display("FAIL csr_drain_hold[%0d]: got valid=%b imm=%h, expected valid=0 imm=00000015", k, id_valid_o, id_imm_o);
      end
      if (k > 0) begin
        n_checks++;
        if (dut.state_q !== ST_DRAIN) begin
          n_fail++; $display("FAIL csr_drain_fsm[%0d]: got %0d, expected %0d", k, dut.state_q, ST_DRAIN);
        end
      end
      step();
    end
    mem_busy_i = 1'b0;
    exp_cnt = exp_cnt + 16'd3;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL csr_drain_release: got valid=%b cnt=%0d, expected valid=1 cnt=%0d", id_valid_o, stall_cnt_o, exp_cnt);
    end
    step();
  endtask

  task automatic test_backpressure();
    ex_ready_i = 1'b0;
    present(32'h500, 32'h123453B7, 32'h12345000, 5'd0, 5'd0, 1'b1);
    step();
    present(32'h504, 32'hFFDFF06F, 32'hFFFFFFFC, 5'd0, 5'd0, 1'b0);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({id_valid_o, if_ready_o, id_inst_o, id_pc_o, stall_cnt_o} !== {1'b1, 1'b0, 32'h123453B7, 32'h500, exp_cnt}) begin
        n_fail++; $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b inst=%h pc=%h cnt=%0d, expected 1 0 123453b7 00000500 %0d",
                           k, id_valid_o, if_ready_o, id_inst_o, id_pc_o, stall_cnt_o, exp_cnt);
      end
      step();
    end
    ex_ready_i = 1'b1;
    present(32'h504, 32'hFFDFF06F, 32'hFFFFFFFC, 5'd0, 5'd0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (if_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL issue_and_accept: got ready=%b, expected 1", if_ready_o);
    end
    step();
    if_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, id_inst_o} !== {1'b1, 32'hFFDFF06F}) begin
      n_fail++; $display("FAIL replace_no_bubble: got valid=%b inst=%h, expected valid=1 inst=ffdff06f", id_valid_o, id_inst_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [6] = '{32'hFE532C23, 32'hFE2088E3, 32'h001000EF, 32'hFFFFF197, 32'hFFF12203, 32'h300120F3};
    logic [31:0] imms  [6] = '{32'hFFFFFFF8, 32'hFFFFFFF0, 32'h00000800, 32'hFFFFF000, 32'hFFFFFFFF, 32'h0};
    logic [4:0]  rs1s  [6] = '{5'd6, 5'd1, 5'd0, 5'd0, 5'd2, 5'd2};
    logic [4:0]  rs2s  [6] = '{5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int unsigned i = 0; i < 6; i++) begin
      present(32'h600 + 32'(i * 4), insts[i], imms[i], rs1s[i], rs2s[i], 1'b1);
      @(negedge clk);
      n_checks++;
      if (if_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL back_to_back_ready[%0d]: got %b, expected 1", i, if_ready_o);
      end
      step();
    end
    if_valid_i = 1'b0;
    @(negedge clk);
    step();
  endtask

  task automatic test_flush();
    present(32'h700, 32'h001101B3, 32'h0, 5'd2, 5'd1, 1'b0);
    step();
    if_valid_i = 1'b0;
    ex_wen_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
    step();
    exp_cnt = exp_cnt + 16'd1;
    flush_i = 1'b1;
    present(32'h704, 32'h00500093, 32'h5, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({id_valid_o, if_ready_o, stall_cnt_o} !== {1'b0, 1'b1, exp_cnt}) begin
      n_fail++; $display("FAIL flush_cycle: got valid=%b ready=%b cnt=%0d, expected 0 1 %0d", id_valid_o, if_ready_o, stall_cnt_o, exp_cnt);
    end
    n_checks++;
    if (dut.state_q !== ST_STALL) begin
      n_fail++; $display("FAIL flush_pre_fsm: got %0d, expected %0d", dut.state_q, ST_STALL);
    end
    step();
    flush_i = 1'b0; if_valid_i = 1'b0; clear_pipe();
    @(negedge clk);
    n_checks++;
    if ({dut.full_q, id_valid_o, stall_cnt_o} !== {1'b0, 1'b0, exp_cnt}) begin
      n_fail++; $display("FAIL flush_after: got full=%b valid=%b cnt=%0d, expected 0 0 %0d", dut.full_q, id_valid_o, stall_cnt_o, exp_cnt);
    end
    n_checks++;
    if (dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL flush_fsm: got %0d, expected %0d", dut.state_q, ST_RUN);
    end
    step();
  endtask

  task automatic test_async_reset();
    present(32'h800, 32'h001101B3, 32'h0, 5'd2, 5'd1, 1'b0);
    step();
    if_valid_i = 1'b0;
    ex_wen_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    n_checks++;
    if ({dut.full_q, if_ready_o, id_valid_o, stall_cnt_o, id_imm_o, id_rs1_o, id_rs2_o} !==
        {1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 5'd0, 5'd0}) begin
      n_fail++; $display("FAIL async_reset: got full=%b ready=%b valid=%b cnt=%0d imm=%h rs1=%0d rs2=%0d, expected 0 1 0 0 0 0 0",
                         dut.full_q, if_ready_o, id_valid_o, stall_cnt_o, id_imm_o, id_rs1_o, id_rs2_o);
    end
    n_checks++;
    if (dut.state_q !== ST_RUN) begin
      n_fail++; $display("FAIL async_reset_fsm: got %0d, expected %0d", dut.state_q, ST_RUN);
    end
    clear_pipe();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    present(32'h900, 32'h001101B3, 32'h0, 5'd2, 5'd1, 1'b1);
    step();
    if_valid_i = 1'b0;
    ex_wen_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd2;
    for (int unsigned i = 1; i <= 65540; i++) begin
      step();
      if (i == 65534) begin
        n_checks++;
        if (stall_cnt_o !== 16'hFFFE) begin
          n_fail++; $display("FAIL stall_cnt_near_max: got %h, expected fffe", stall_cnt_o);
        end
      end
    end
    n_checks++;
    if ({stall_cnt_o, id_valid_o} !== {16'hFFFF, 1'b0}) begin
      n_fail++; $display("FAIL stall_cnt_saturate: got cnt=%h valid=%b, expected cnt=ffff valid=0", stall_cnt_o, id_valid_o);
    end
    clear_pipe();
    @(negedge clk);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_false_hazard();
    test_load_use();
    test_raw_producers();
    test_csr_drain();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturation();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending issues, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode-stage issue controller for the in-order RISC-V core. It owns the single ID pipeline register between fetch and execute and decides each cycle whether the held instruction may issue to EX. Issue is held back by three conditions: a load-use/RAW hazard, CSR serialization, and EX back-pressure. The block presents the sign/zero-extended immediate, source register indices and PC to EX, and counts stall cycles for performance monitoring.

## Interface
- No parameters. Widths are fixed by the RV32I datapath: XLEN=32, register index=5.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_valid_i  in  1  fetch presents an instruction
- if_inst_i  in  32  fetched instruction
- if_pc_i  in  32  PC of fetched instruction
- if_ready_o  out  1  ID register can accept this cycle
- id_valid_o  out  1  held instruction is issuable to EX
- id_inst_o  out  32  held instruction
- id_pc_o  out  32  held PC
- id_imm_o  out  32  extended immediate of held instruction
- id_rs1_o / id_rs2_o  out  5  source indices (0 when the source is unused)
- ex_ready_i  in  1  EX accepts the issued instruction
- ex_rd_i  in  5  destination of the instruction in EX
- ex_wen_i  in  1  EX instruction writes rd
- ex_is_load_i  in  1  EX instruction is a load
- mem_rd_i  in  5  destination of the instruction in MEM
- mem_wen_i  in  1  MEM instruction writes rd
- ex_busy_i / mem_busy_i  in  1  stage holds a valid instruction
- flush_i  in  1  redirect from EX; discard ID contents
- stall_cnt_o  out  16  saturating count of hazard/drain stall cycles

## Operation
- ID register state: full, inst, pc. Load when if_valid_i && if_ready_o. Issue fire = id_valid_o && ex_ready_i.
- if_ready_o = !full || fire || flush_i.
- Source use:
  - rs1 is used by every format except U and J.
  - rs2 is used by R, S and B formats.
  - An unused source reports index 0. A match on x0 is never a hazard.
- Hazard with BYPASS_EN defined: a used rs matches ex_rd_i while ex_wen_i && ex_is_load_i.
- Hazard without BYPASS_EN: a used rs matches ex_rd_i with ex_wen_i, or matches mem_rd_i with mem_wen_i.
- FSM states: RUN, STALL, DRAIN.
  - RUN: if full and hazard, go to STALL. If full and opcode is CSR (`Itype_C`) and ex_busy_i||mem_busy_i, go to DRAIN.
  - STALL: return to RUN in the first cycle the hazard is clear.
  - DRAIN: return to RUN when !ex_busy_i && !mem_busy_i.
- id_valid_o = full && !hazard && !(CSR && (ex_busy_i||mem_busy_i)) && !flush_i. The FSM state is observational; the issue decision is combinational.
- stall_cnt_o increments by 1 each cycle that full && !id_valid_o && !flush_i. It saturates at 0xFFFF.
- Immediate formats:
  - I (jump, load, ALU): sign-extended [31:20].
  - CSR immediate variants: zero-extended [19:15]. CSR register variants: 0.
  - U: {[31:12],12'b0}.
  - J and B: sign-extended, bit0=0.
  - S: sign-extended {[31:25],[11:7]}.
  - Any other opcode: 0.

## Timing
- Reset values: full=0, inst=0, pc=0, FSM=RUN, stall_cnt_o=0. Therefore if_ready_o=1, id_valid_o=0, id_imm_o=0, and id_rs1_o and id_rs2_o are 0.
- Latency: an instruction accepted at edge N is presented on id_*_o from cycle N+1. It can issue that same cycle, so there is 0 added bubbles when no hazard.
- Simultaneous issue and accept in one cycle: the register is replaced with no bubble.
- flush_i takes priority over everything:
  - id_valid_o is forced to 0 and full clears at the next edge.
  - A same-cycle IF instruction is discarded, not loaded.
  - The FSM goes to RUN and stall_cnt_o does not increment.
- ex_ready_i=0 with id_valid_o=1: the instruction holds and id_*_o stays stable. This is not counted as a stall.
- Asynchronous reset mid-stall or mid-drain returns everything to reset values immediately.

## Configuration
- BYPASS_EN defined: EX/MEM forwarding exists. Only load-use stalls for one cycle.
- BYPASS_EN undefined: no forwarding. Any RAW dependence against EX or MEM stalls until the producer retires past MEM.

## Structure
- Opcode and func3 constants come from the shared define.v: `Itype_*`, `Utype_*`, `Jtype_J`, `Btype`, `Stype`, `I_CSR*`. FSM state encodings are added there.
- One sub-module is natural: id_hazard_chk. It is combinational, takes rs use flags, indices and EX/MEM destination info, and outputs hazard. It contains the BYPASS_EN split.
- The immediate is produced by instantiating the existing immediate generator on the held instruction.

## Test plan
- Reset release, then IF presents addi x1,x0,5 (0x00500093) at pc 0x100 → next cycle id_valid_o=1, id_imm_o=0x5, id_rs1_o=0, id_rs2_o=0.
- lw x2 in EX (ex_is_load_i=1, ex_rd_i=2), ID holds add x3,x2,x1 → id_valid_o=0 for one cycle, stall_cnt_o=1, then issue.
- BYPASS_EN undefined, mem_rd_i=1, mem_wen_i=1, ID uses rs1=x1 → stall until mem_wen_i drops. Repeat with BYPASS_EN defined → no stall.
- csrrwi in ID with mem_busy_i=1 for 3 cycles → FSM in DRAIN, id_valid_o=0 for 3 cycles, id_imm_o={27'b0,zimm}, stall_cnt_o += 3.
- Stalled instruction plus flush_i with if_valid_i=1 in the same cycle → next cycle full=0, id_valid_o=0, FSM=RUN, the IF instruction is not held.
- Force 65540 hazard cycles → stall_cnt_o saturates at 0xFFFF.
